// File: rtl/ohs_boost_pi_ctrl.sv
// ohs_boost_pi_ctrl: fixed-point PI output-voltage controller for the boost model.
// Per ce sample it produces a clamped duty with anti-windup and the matching pwm_generator compare value.
module ohs_boost_pi_ctrl #(
    parameter int data_width    = 32,
    parameter int data_decimal  = 22,
    parameter int counter_width = 32
) (
    input  logic                     aclk,
    input  logic                     resetn,
    input  logic                     ce,
    input  logic                     enable,
    input  logic [data_width-1:0]    vref,
    input  logic [data_width-1:0]    vfb,
    input  logic [data_width-1:0]    kp,
    input  logic [data_width-1:0]    ki,
    input  logic [data_width-1:0]    duty_min,
    input  logic [data_width-1:0]    duty_max,
    input  logic [counter_width-1:0] period,
    output logic [data_width-1:0]    duty,
    output logic [counter_width-1:0] comparator,
    output logic                     valid,
    output logic                     sat_hi,
    output logic                     sat_lo,
    output logic                     busy,
    output logic                     overrun
);
    localparam int dw = data_width;
    localparam int w2 = 2 * data_width;
    localparam logic signed [w2-1:0] sat_max = (w2'(1) <<< (dw - 1)) - 1;
    localparam logic signed [w2-1:0] sat_min = -sat_max - 1;

    typedef enum logic [2:0] {IDLE, ERR, MULP, MULI, ACC, OUT} state_t;

    state_t state_q, state_d;
    logic signed [dw-1:0] vref_q, vfb_q, kp_q, ki_q, dmin_q, dmax_q;
    logic signed [dw-1:0] e_q, p_q, ip_q, integ_q, u_q, duty_q;
    logic [counter_width-1:0] period_q, cmp_q;
    logic hi_q, lo_q, sat_hi_q, sat_lo_q, valid_q, overrun_q;
    logic signed [dw-1:0] mul_res, i_next, u_raw, u_clamp;
    logic hi_d, lo_d, hold;

    function automatic logic signed [dw-1:0] sat(input logic signed [w2-1:0] x);
        return x > sat_max ? dw'(sat_max) : x < sat_min ? dw'(sat_min) : dw'(x);
    endfunction

    // One multiplier serves both gains: kp in MULP, ki in MULI.
    assign mul_res = sat((w2'(state_q == MULP ? kp_q : ki_q) * w2'(e_q)) >>> data_decimal);
    assign i_next  = sat(w2'(integ_q) + w2'(ip_q));
    assign u_raw   = sat(w2'(p_q) + w2'(i_next));
    assign hi_d    = u_raw > dmax_q;
    assign lo_d    = u_raw < dmin_q;
    assign u_clamp = hi_d ? dmax_q : lo_d ? dmin_q : u_raw;
    assign hold    = (hi_d && ip_q > 0) || (lo_d && ip_q < 0);

    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = !enable ? IDLE :
                  state_q == IDLE ? (ce ? ERR : IDLE) :
                  state_q == OUT  ? IDLE : state_t'(state_q + 3'd1);
    end

    always_comb begin
        busy       = state_q != IDLE;
        duty       = duty_q;
        comparator = cmp_q;
        valid      = valid_q;
        sat_hi     = sat_hi_q;
        sat_lo     = sat_lo_q;
        overrun    = overrun_q;
    end

    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            {vref_q, vfb_q, kp_q, ki_q, dmin_q, dmax_q} <= '0;
            {e_q, p_q, ip_q, integ_q, u_q, duty_q}      <= '0;
            {period_q, cmp_q}                           <= '0;
            {hi_q, lo_q, sat_hi_q, sat_lo_q, valid_q, overrun_q} <= '0;
        end else begin
            overrun_q <= overrun_q | (ce & (state_q != IDLE));
            if (!enable) begin
                integ_q  <= '0;
                duty_q   <= '0;
                cmp_q    <= '0;
                sat_hi_q <= 1'b0;
                sat_lo_q <= 1'b0;
                valid_q  <= 1'b0;
            end else begin
                valid_q <= state_q == OUT;
                if (state_q == IDLE && ce) begin
                    vref_q   <= vref;
                    vfb_q    <= vfb;
                    kp_q     <= kp;
                    ki_q     <= ki;
                    dmin_q   <= duty_min;
                    dmax_q   <= duty_max;
                    period_q <= period;
                end
                if (state_q == ERR)  e_q  <= sat(w2'(vref_q) - w2'(vfb_q));
                if (state_q == MULP) p_q  <= mul_res;
                if (state_q == MULI) ip_q <= mul_res;
                if (state_q == ACC) begin
                    u_q  <= u_clamp;
                    hi_q <= hi_d;
                    lo_q <= lo_d;
                    if (!hold) integ_q <= i_next;
                end
                if (state_q == OUT) begin
                    duty_q   <= u_q;
                    cmp_q    <= counter_width'((w2'($unsigned(u_q)) * w2'(period_q)) >> data_decimal);
                    sat_hi_q <= hi_q;
                    sat_lo_q <= lo_q;
                end
            end
        end
    end
endmodule

// File: tb/tb_ohs_boost_pi_ctrl.sv
// tb_ohs_boost_pi_ctrl: directed vector table plus hand-written sequences for
// enable drop, overrun and asynchronous reset of ohs_boost_pi_ctrl.
module tb_ohs_boost_pi_ctrl;
    localparam int ONE = 4194304;
    localparam int DMAX = 3774873;
    localparam int KI = 419430;

    logic aclk = 1'b0;
    logic resetn, ce, enable;
    logic [31:0] vref, vfb, kp, ki, duty_min, duty_max, period;
    logic [31:0] duty, comparator;
    logic valid, sat_hi, sat_lo, busy, overrun;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] vref, vfb, kp, ki, dmin, dmax, period;
        int          rep;
        logic [31:0] duty, cmp;
        logic        hi, lo;
    } vec_t;
    vec_t tv[14];

    ohs_boost_pi_ctrl dut (
        .aclk(aclk), .resetn(resetn), .ce(ce), .enable(enable),
        .vref(vref), .vfb(vfb), .kp(kp), .ki(ki),
        .duty_min(duty_min), .duty_max(duty_max), .period(period),
        .duty(duty), .comparator(comparator), .valid(valid),
        .sat_hi(sat_hi), .sat_lo(sat_lo), .busy(busy), .overrun(overrun)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        vref = v.vref; vfb = v.vfb; kp = v.kp; ki = v.ki;
        duty_min = v.dmin; duty_max = v.dmax; period = v.period;
    endtask

    // Called at a negedge; returns at the negedge where valid is seen (or the bound expires).
    task automatic run_ce(output int lat, output logic busy_seen);
        ce = 1'b1;
        @(negedge aclk);
        ce = 1'b0;
        busy_seen = busy;
        lat = 0;
        while (!valid && lat < 20) begin
            @(negedge aclk);
            lat++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, nv;
        logic bz;
        logic [31:0] cap;
        tv[0] = '{2*ONE, ONE, 2097152, 0, 0, DMAX, 1000, 1, 2097152, 500, 1'b0, 1'b0};
        for (int k = 1; k <= 9; k++)
            tv[k] = '{2*ONE, ONE, 0, KI, 0, DMAX, 1000, 1, KI*k, 100*k-1, 1'b0, 1'b0};
        tv[10] = '{2*ONE, ONE,   0,       KI, 0,       DMAX, 1000, 21, DMAX,    899,  1'b1, 1'b0};
        tv[11] = '{2*ONE, 3*ONE, 0,       KI, 0,       DMAX, 1000, 1,  3355440, 799,  1'b0, 1'b0};
        tv[12] = '{0,     2*ONE, 8388608, KI, 1048576, DMAX, 1000, 1,  1048576, 250,  1'b0, 1'b1};
        tv[13] = '{ONE,   ONE,   0,       0,  0,       DMAX, 2000, 1,  3355440, 1599, 1'b0, 1'b0};

        resetn = 1'b0; ce = 1'b0; enable = 1'b0;
        drive(tv[0]);
        repeat (2) @(negedge aclk);
        chk("reset duty", duty, 0);
        chk("reset comparator", comparator, 0);
        chk("reset valid", valid, 0);
        chk("reset busy", busy, 0);
        chk("reset overrun", overrun, 0);
        chk("reset sat_hi", sat_hi, 0);
        resetn = 1'b1;
        enable = 1'b1;
        @(negedge aclk);

        for (int i = 0; i < 14; i++) begin
            drive(tv[i]);
            for (int r = 0; r < tv[i].rep; r++) begin
                run_ce(lat, bz);
                chk($sformatf("v%0d.%0d busy", i, r), bz, 1);
                chk($sformatf("v%0d.%0d latency", i, r), lat, 5);
                chk($sformatf("v%0d.%0d duty", i, r), duty, tv[i].duty);
                chk($sformatf("v%0d.%0d comparator", i, r), comparator, tv[i].cmp);
                chk($sformatf("v%0d.%0d sat_hi", i, r), sat_hi, tv[i].hi);
                chk($sformatf("v%0d.%0d sat_lo", i, r), sat_lo, tv[i].lo);
                @(negedge aclk);
                chk($sformatf("v%0d.%0d valid one cycle", i, r), valid, 0);
            end
        end

        // enable dropped mid-computation: aborted, no valid, outputs cleared
        drive(tv[1]);
        ce = 1'b1;
        @(negedge aclk);
        ce = 1'b0;
        @(negedge aclk);
        enable = 1'b0;
        nv = 0;
        repeat (8) begin
            @(negedge aclk);
            if (valid) nv++;
            enable = 1'b1;
        end
        chk("abort valid count", nv, 0);
        chk("abort duty", duty, 0);
        chk("abort comparator", comparator, 0);
        run_ce(lat, bz);
        chk("after abort duty", duty, KI);
        @(negedge aclk);

        // enable low for a single idle cycle clears outputs and integrator
        enable = 1'b0;
        @(negedge aclk);
        chk("drop duty", duty, 0);
        chk("drop comparator", comparator, 0);
        chk("drop valid", valid, 0);
        chk("drop busy", busy, 0);
        enable = 1'b1;
        run_ce(lat, bz);
        chk("drop next latency", lat, 5);
        chk("drop next duty", duty, KI);
        chk("drop next comparator", comparator, 99);
        @(negedge aclk);

        // second ce two cycles after the first is ignored and flagged
        chk("overrun before", overrun, 0);
        ce = 1'b1;
        @(negedge aclk);
        ce = 1'b0;
        @(negedge aclk);
        ce = 1'b1;
        @(negedge aclk);
        ce = 1'b0;
        nv = 0;
        cap = '0;
        repeat (12) begin
            @(negedge aclk);
            if (valid) begin
                nv++;
                cap = duty;
            end
        end
        chk("overrun valid count", nv, 1);
        chk("overrun duty", cap, 2*KI);
        chk("overrun flag", overrun, 1);

        // asynchronous reset while in MULI
        ce = 1'b1;
        @(negedge aclk);
        ce = 1'b0;
        @(negedge aclk);
        @(negedge aclk);
        #2 resetn = 1'b0;
        #1;
        chk("async duty", duty, 0);
        chk("async comparator", comparator, 0);
        chk("async busy", busy, 0);
        chk("async overrun", overrun, 0);
        chk("async valid", valid, 0);
        @(negedge aclk);
        resetn = 1'b1;
        @(negedge aclk);
        run_ce(lat, bz);
        chk("post reset latency", lat, 5);
        chk("post reset duty", duty, KI);
        chk("post reset comparator", comparator, 99);
        chk("post reset overrun", overrun, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
